// File: rtl/vector_frame_accumulator.sv
// Lane-wise frame accumulator: folds per-chain vectors (pass / sum / max) until eof,
// then emits one result vector with the number of vectors folded into it.
module vector_frame_accumulator #(
   parameter int N                  = 8,
   parameter int DATA_WIDTH         = 32,
   parameter int MAX_CHAINS         = 4,
   parameter int PERSONAL_CONFIG_ID = 1,
   localparam int CW                = $clog2(MAX_CHAINS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid_in,
   input  logic                  eof_in,
   input  logic [CW-1:0]         chainId_in,
   input  logic                  tracing,
   input  logic [7:0]            configId,
   input  logic [7:0]            configData,
   input  logic [DATA_WIDTH-1:0] vector_in [N-1:0],
   output logic                  valid_out,
   output logic                  eof_out,
   output logic [DATA_WIDTH-1:0] vector_out [N-1:0],
   output logic [15:0]           count_out
);

   localparam logic [7:0] MODE_SUM = 8'd1;
   localparam logic [7:0] MODE_MAX = 8'd2;

   logic [7:0]            mode       [MAX_CHAINS];
   logic [DATA_WIDTH-1:0] acc        [MAX_CHAINS][N];
   logic [15:0]           cnt        [MAX_CHAINS];
   logic                  frame_open [MAX_CHAINS];

   logic [7:0]            mode_sel;
   logic                  fold_en;
   logic                  cfg_hit;
   logic [DATA_WIDTH-1:0] fold_p0 [N];
   logic [15:0]           cnt_p0;

   function automatic logic [15:0] sat_inc(input logic [15:0] x);
      return (x == 16'hFFFF) ? x : x + 16'd1;
   endfunction

   // SUM wraps modulo 2^DATA_WIDTH; MAX is an unsigned compare.
   function automatic logic [DATA_WIDTH-1:0] fold(input logic [7:0] m,
                                                  input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
      if (m == MODE_MAX) return (b > a) ? b : a;
      return a + b;
   endfunction

   // Stage p0: fold the incoming vector into the selected chain's running state
   always_comb begin
      mode_sel = mode[chainId_in];
      fold_en  = (mode_sel == MODE_SUM) || (mode_sel == MODE_MAX);
      cfg_hit  = (configId == 8'(PERSONAL_CONFIG_ID));
      cnt_p0   = frame_open[chainId_in] ? sat_inc(cnt[chainId_in]) : 16'd1;
      for (int i = 0; i < N; i++) begin
         fold_p0[i] = frame_open[chainId_in] ?
                      fold(mode_sel, acc[chainId_in][i], vector_in[i]) : vector_in[i];
      end
   end

   // Stage p1: registered state update and result outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_out <= 1'b0;
         eof_out   <= 1'b0;
         count_out <= '0;
         for (int i = 0; i < N; i++) vector_out[i] <= '0;
         for (int c = 0; c < MAX_CHAINS; c++) begin
            mode[c]       <= '0;
            cnt[c]        <= '0;
            frame_open[c] <= 1'b0;
            for (int i = 0; i < N; i++) acc[c][i] <= '0;
         end
      end else begin
         valid_out <= 1'b0;
         eof_out   <= 1'b0;
         if (!tracing) begin
            if (cfg_hit) begin
               mode[chainId_in]       <= configData;
               cnt[chainId_in]        <= '0;
               frame_open[chainId_in] <= 1'b0;
               for (int i = 0; i < N; i++) acc[chainId_in][i] <= '0;
            end
         end else if (valid_in) begin
            if (!fold_en) begin
               valid_out <= 1'b1;
               eof_out   <= eof_in;
               count_out <= 16'd1;
               for (int i = 0; i < N; i++) vector_out[i] <= vector_in[i];
            end else if (!eof_in) begin
               cnt[chainId_in]        <= cnt_p0;
               frame_open[chainId_in] <= 1'b1;
               for (int i = 0; i < N; i++) acc[chainId_in][i] <= fold_p0[i];
            end else begin
               valid_out <= 1'b1;
               eof_out   <= 1'b1;
               count_out <= cnt_p0;
               for (int i = 0; i < N; i++) vector_out[i] <= fold_p0[i];
               cnt[chainId_in]        <= '0;
               frame_open[chainId_in] <= 1'b0;
               for (int i = 0; i < N; i++) acc[chainId_in][i] <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_vector_frame_accumulator.sv
// Bench for vector_frame_accumulator: vector table, corner sequences, random traffic vs. a frame-list model.
module tb_vector_frame_accumulator;

   localparam int N  = 8;
   localparam int DW = 32;
   localparam int NC = 4;
   localparam int PW = N * DW;

   logic          clk = 1'b0;
   logic          reset;
   logic          valid_in, eof_in, tracing;
   logic [1:0]    chainId_in;
   logic [7:0]    configId, configData;
   logic [DW-1:0] vin  [N-1:0];
   logic          valid_out, eof_out;
   logic [DW-1:0] vout [N-1:0];
   logic [15:0]   count_out;

   int errors = 0;
   int checks = 0;

   vector_frame_accumulator #(.N(N), .DATA_WIDTH(DW), .MAX_CHAINS(NC), .PERSONAL_CONFIG_ID(1)) dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .eof_in(eof_in),
      .chainId_in(chainId_in), .tracing(tracing), .configId(configId),
      .configData(configData), .vector_in(vin), .valid_out(valid_out),
      .eof_out(eof_out), .vector_out(vout), .count_out(count_out));

   always #5 clk = ~clk;

   typedef struct {
      bit          tr, vld, eof;
      logic [1:0]  ch;
      logic [7:0]  cid, cdata;
      logic [PW-1:0] v;
      bit          ev, ee;
      logic [PW-1:0] evec;
      logic [15:0] ecnt;
   } rec_t;

   rec_t tbl [$];

   function automatic rec_t rec(bit tr, bit vld, bit eof, logic [1:0] ch, logic [7:0] cid,
                                logic [7:0] cdata, logic [PW-1:0] v, bit ev, bit ee,
                                logic [PW-1:0] evec, logic [15:0] ecnt);
      rec_t r;
      r.tr = tr; r.vld = vld; r.eof = eof; r.ch = ch; r.cid = cid; r.cdata = cdata;
      r.v = v; r.ev = ev; r.ee = ee; r.evec = evec; r.ecnt = ecnt;
      return r;
   endfunction

   function automatic logic [PW-1:0] seq(int s);
      logic [PW-1:0] r;
      for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'(s + i);
      return r;
   endfunction

   function automatic logic [PW-1:0] splat(logic [DW-1:0] x);
      logic [PW-1:0] r;
      for (int i = 0; i < N; i++) r[i*DW +: DW] = x;
      return r;
   endfunction

   task automatic set_vin(logic [PW-1:0] p);
      for (int i = 0; i < N; i++) vin[i] = p[i*DW +: DW];
   endtask

   task automatic drive(bit tr, bit vld, bit eof, logic [1:0] ch, logic [7:0] cid,
                        logic [7:0] cdata, logic [PW-1:0] v);
      tracing = tr; valid_in = vld; eof_in = eof; chainId_in = ch;
      configId = cid; configData = cdata; set_vin(v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(string name, bit ev, bit ee, logic [PW-1:0] evec, logic [15:0] ecnt);
      logic [PW-1:0] act;
      for (int i = 0; i < N; i++) act[i*DW +: DW] = vout[i];
      checks++;
      if (valid_out !== ev || (ev && (eof_out !== ee || act !== evec || count_out !== ecnt))) begin
         errors++;
         $display("FAIL %s: got valid=%b eof=%b cnt=%0d vec=%h ; want valid=%b eof=%b cnt=%0d vec=%h",
                  name, valid_out, eof_out, count_out, act, ev, ee, ecnt, evec);
      end
   endtask

   // Reference model: per-chain list of the vectors of the open frame, reduced at eof.
   int            mdl_mode [NC];
   logic [PW-1:0] fq [NC][$];

   function automatic logic [PW-1:0] reduce_frame(int ch);
      logic [PW-1:0] r;
      logic [DW-1:0] a, x;
      for (int i = 0; i < N; i++) begin
         a = fq[ch][0][i*DW +: DW];
         for (int k = 1; k < fq[ch].size(); k++) begin
            x = fq[ch][k][i*DW +: DW];
            if (mdl_mode[ch] == 1) a = a + x;
            else if (x > a) a = x;
         end
         r[i*DW +: DW] = a;
      end
      return r;
   endfunction

   function automatic logic [DW-1:0] rnd_lane();
      case ($urandom_range(0, 3))
         0: return 32'hFFFF_FFFF;
         1: return DW'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [PW-1:0] v, evec;
      bit tr, vld, eof, ev, ee;
      logic [1:0] ch;
      logic [7:0] cid, cd;
      logic [15:0] ecnt;
      int sz;

      drive(1, 0, 0, 0, 0, 0, '0);
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      #1;
      check("reset_state", 1'b0, 1'b0, '0, 16'd0);
      checks++;
      if (eof_out !== 1'b0 || count_out !== 16'd0 || vout[0] !== '0 || vout[N-1] !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got eof=%b cnt=%0d lane0=%h ; want eof=0 cnt=0 lane0=0",
                  eof_out, count_out, vout[0]);
      end

      tbl.push_back(rec(1, 1, 0, 0, 0, 0, seq(1),  1, 0, seq(1), 1));
      tbl.push_back(rec(1, 1, 1, 0, 0, 0, seq(9),  1, 1, seq(9), 1));
      tbl.push_back(rec(0, 0, 0, 2, 1, 1, '0,      0, 0, '0, 0));
      tbl.push_back(rec(1, 1, 0, 2, 0, 0, splat(5), 0, 0, '0, 0));
      tbl.push_back(rec(1, 1, 0, 2, 0, 0, splat(5), 0, 0, '0, 0));
      tbl.push_back(rec(1, 1, 1, 2, 0, 0, splat(5), 1, 1, splat(15), 3));
      tbl.push_back(rec(1, 0, 0, 2, 0, 0, '0,      0, 0, '0, 0));
      tbl.push_back(rec(0, 0, 0, 0, 1, 2, '0,      0, 0, '0, 0));
      tbl.push_back(rec(0, 0, 0, 1, 1, 1, '0,      0, 0, '0, 0));
      tbl.push_back(rec(1, 1, 0, 0, 0, 0, splat(3), 0, 0, '0, 0));
      tbl.push_back(rec(1, 1, 0, 1, 0, 0, splat(4), 0, 0, '0, 0));
      tbl.push_back(rec(1, 1, 0, 0, 0, 0, splat(9), 0, 0, '0, 0));
      tbl.push_back(rec(1, 1, 1, 1, 0, 0, splat(4), 1, 1, splat(8), 2));
      tbl.push_back(rec(1, 1, 1, 0, 0, 0, splat(2), 1, 1, splat(9), 3));
      tbl.push_back(rec(0, 0, 0, 3, 1, 1, '0,      0, 0, '0, 0));
      tbl.push_back(rec(1, 1, 0, 3, 0, 0, splat(32'hFFFF_FFFF), 0, 0, '0, 0));
      tbl.push_back(rec(1, 1, 1, 3, 0, 0, splat(2), 1, 1, splat(1), 2));
      tbl.push_back(rec(0, 1, 1, 3, 5, 2, splat(6), 0, 0, '0, 0));
      tbl.push_back(rec(1, 1, 0, 3, 0, 0, splat(7), 0, 0, '0, 0));
      tbl.push_back(rec(1, 1, 1, 3, 0, 0, splat(1), 1, 1, splat(8), 2));
      tbl.push_back(rec(1, 1, 0, 3, 0, 0, splat(3), 0, 0, '0, 0));
      tbl.push_back(rec(1, 0, 1, 3, 0, 0, splat(9), 0, 0, '0, 0));
      tbl.push_back(rec(1, 1, 1, 3, 0, 0, splat(4), 1, 1, splat(7), 2));

      foreach (tbl[k]) begin
         drive(tbl[k].tr, tbl[k].vld, tbl[k].eof, tbl[k].ch, tbl[k].cid, tbl[k].cdata, tbl[k].v);
         tick();
         check($sformatf("vec%0d", k), tbl[k].ev, tbl[k].ee, tbl[k].evec, tbl[k].ecnt);
      end

      // Reconfiguring a chain mid-frame discards the partial frame (chain 1 is SUM).
      drive(1, 1, 0, 1, 0, 0, seq(1));   tick();
      drive(1, 1, 0, 1, 0, 0, seq(1));   tick();
      drive(0, 0, 0, 1, 1, 1, '0);       tick();
      drive(1, 1, 1, 1, 0, 0, seq(100)); tick();
      check("reconfig_midframe", 1, 1, seq(100), 1);

      // Asynchronous reset mid-frame: frame lost, chain returns to PASS.
      drive(1, 1, 0, 1, 0, 0, seq(1));   tick();
      drive(1, 1, 0, 1, 0, 0, seq(1));   tick();
      drive(1, 0, 0, 1, 0, 0, '0);
      #2 reset = 1'b1;
      #1 check("async_reset", 0, 0, '0, 0);
      checks++;
      if (count_out !== 16'd0 || vout[3] !== '0) begin
         errors++;
         $display("FAIL async_reset_data: got cnt=%0d lane3=%h ; want cnt=0 lane3=0", count_out, vout[3]);
      end
      reset = 1'b0;
      drive(1, 1, 1, 1, 0, 0, seq(50)); tick();
      check("post_reset_frame", 1, 1, seq(50), 1);
      drive(1, 1, 0, 1, 0, 0, seq(60)); tick();
      check("post_reset_pass", 1, 0, seq(60), 1);

      // 70000-vector SUM frame: count saturates.
      drive(0, 0, 0, 2, 1, 1, '0); tick();
      drive(1, 1, 0, 2, 0, 0, splat(1));
      repeat (69999) @(posedge clk);
      #1 check("long_frame_quiet", 0, 0, '0, 0);
      eof_in = 1'b1;
      tick();
      check("count_saturate", 1, 1, splat(32'(70000)), 16'd65535);

      // Randomized traffic against the frame-list model.
      drive(1, 0, 0, 0, 0, 0, '0);
      reset = 1'b1; tick(); reset = 1'b0;
      for (int c = 0; c < NC; c++) begin mdl_mode[c] = 0; fq[c].delete(); end
      for (int n = 0; n < 1500; n++) begin
         tr  = ($urandom_range(0, 7) != 0);
         vld = ($urandom_range(0, 4) != 0);
         eof = ($urandom_range(0, 3) == 0);
         ch  = 2'($urandom_range(0, NC - 1));
         cid = ($urandom_range(0, 2) != 0) ? 8'd1 : 8'($urandom_range(2, 255));
         case ($urandom_range(0, 4))
            0: cd = 8'd0; 1: cd = 8'd1; 2: cd = 8'd2; 3: cd = 8'd3; default: cd = 8'($urandom);
         endcase
         for (int i = 0; i < N; i++) v[i*DW +: DW] = rnd_lane();
         ev = 0; ee = 0; evec = '0; ecnt = '0;
         if (!tr) begin
            if (cid == 8'd1) begin mdl_mode[ch] = int'(cd); fq[ch].delete(); end
         end else if (vld) begin
            if (mdl_mode[ch] == 1 || mdl_mode[ch] == 2) begin
               fq[ch].push_back(v);
               if (eof) begin
                  sz = fq[ch].size();
                  ev = 1; ee = 1; evec = reduce_frame(ch);
                  ecnt = (sz > 65535) ? 16'hFFFF : 16'(sz);
                  fq[ch].delete();
               end
            end else begin
               ev = 1; ee = eof; evec = v; ecnt = 16'd1;
            end
         end
         drive(tr, vld, eof, ch, cid, cd, v);
         tick();
         check($sformatf("rand%0d", n), ev, ee, evec, ecnt);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
